// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg
//   Shared definitions for the memory loader: FSM state encoding, the byte
//   width of the incoming stream, and a helper that gives bytes-per-word for a
//   given data width.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int BYTE_WIDTH = 8;

  // Bytes per memory word; data_width must be a multiple of BYTE_WIDTH.
  function automatic int bpw(input int data_width);
    return data_width / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/mem_loader_byte_assembler.sv
// mem_loader_byte_assembler
//   Packs a byte stream little-endian into DATA_WIDTH words. Each accepted
//   byte shifts in from the top, so after BPW loads the first byte sits in
//   bits [7:0] and the last in the top byte.
// Ports
//   clk        in   clock, posedge
//   rst        in   asynchronous active-low reset
//   load       in   accept byte_in this cycle
//   clear      in   restart assembly at byte 0
//   byte_in    in   8-bit data byte
//   word       out  assembled word register
//   word_full  out  the byte being loaded this cycle completes the word
module mem_loader_byte_assembler
  import mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_full
);

  localparam int BPW = bpw(DATA_WIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST = CW'(BPW - 1);

  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shifted;

  generate
    if (BPW == 1) begin : g_single
      assign shifted = byte_in;
    end else begin : g_shift
      assign shifted = {byte_in, word[DATA_WIDTH-1:BYTE_WIDTH]};
    end
  endgenerate

  assign word_full = load && (cnt == LAST);

  // Counter wraps to 0 on the completing byte, so the next word starts clean
  // without needing an explicit clear from the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
    end else if (load) begin
      word <= shifted;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader
//   Feeds a Memory block from a byte stream: bytes arrive over valid/ready,
//   are packed little-endian into DATA_WIDTH words and written to sequential
//   addresses from 0. The load ends after the halt word is written (the halt
//   word itself is stored) or when the last address has been written.
//   Optional build macro MEM_LOADER_CHECKSUM_EN adds a running XOR of every
//   written word on port checksum.
// Ports
//   clk, rst          clock (posedge), asynchronous active-low reset
//   start             begins a load; honoured only in IDLE or DONE
//   rx_data/valid     incoming byte and its valid
//   rx_ready          byte accepted on this edge when rx_valid is also high
//   mem_address, mem_write_enable, mem_data_in   Memory write port
//   busy, done        status: collecting/writing, finished
//   overflow          memory filled without a halt word (meaningful in DONE)
//   word_count        words written in the current load
//   checksum          (MEM_LOADER_CHECKSUM_EN only) XOR of written words
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DATA_WIDTH'(32'hFFFF_FFFF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   word_count
`ifdef MEM_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  // word_count value at which the write in progress fills the last address.
  localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] asm_word;
  logic                  word_full;
  logic                  start_load;
  logic                  byte_load;
  logic                  is_halt;
  logic                  mem_full;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign start_load = start && ((state == IDLE) || (state == DONE));
  assign byte_load  = rx_valid && rx_ready;
  assign is_halt    = (asm_word == HALT_WORD);
  assign mem_full   = (word_count == LAST_IDX);

  mem_loader_byte_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_byte_assembler (
    .clk       (clk),
    .rst       (rst),
    .load      (byte_load),
    .clear     (start_load),
    .byte_in   (rx_data),
    .word      (asm_word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx         = state;
    rx_ready         = 1'b0;
    mem_write_enable = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = COLLECT;
      end
      COLLECT: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (word_full) state_nx = WRITE;
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        busy             = 1'b1;
        state_nx         = (is_halt || mem_full) ? DONE : COLLECT;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = COLLECT;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The Memory port shows the live address/word during WRITE and keeps
  // presenting the last written pair afterwards.
  assign mem_address = (state == WRITE) ? word_count[ADDR_WIDTH-1:0] : addr_q;
  assign mem_data_in = (state == WRITE) ? asm_word : data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count <= '0;
      overflow   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else if (start_load) begin
      word_count <= '0;
      overflow   <= 1'b0;
    end else if (state == WRITE) begin
      word_count <= word_count + 1'b1;
      overflow   <= !is_halt && mem_full;
      addr_q     <= word_count[ADDR_WIDTH-1:0];
      data_q     <= asm_word;
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if (start_load) begin
      checksum <= '0;
    end else if (state == WRITE) begin
      checksum <= checksum ^ asm_word;
    end
  end
`endif

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader
//   Scoreboard bench for mem_loader (default parameters: 32-bit words,
//   64-word memory). Stimulus pushes each expected {address, data} write
//   into a queue; a monitor pops and compares on every write-enable cycle.
//   Status outputs are compared directly at chosen points.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [5:0]  mem_address;
  logic        mem_write_enable;
  logic [31:0] mem_data_in;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [6:0]  word_count;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  mem_loader dut (
`ifdef MEM_LOADER_CHECKSUM_EN
    .checksum         (checksum),
`endif
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_data_in      (mem_data_in),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow),
    .word_count       (word_count)
  );

  int          total  = 0;
  int          passed = 0;
  int          pushes = 0;
  int          writes_seen = 0;
  logic [37:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor: every write cycle must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_write_enable === 1'b1) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          fail("unexpected_write");
        end else begin
          logic [37:0] e;
          e = exp_q.pop_front();
          chk("write_addr", 64'(mem_address), 64'(e[37:32]));
          chk("write_data", 64'(mem_data_in), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("rx_ready_timeout");
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic expect_write(input logic [5:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
    pushes++;
  endtask

  task automatic send_word(input logic [5:0] a, input logic [31:0] d, input bit rnd);
    expect_write(a, d);
    for (int k = 0; k < 4; k++)
      send_byte(d[8*k +: 8], rnd ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    #12;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_rx_ready", 64'(rx_ready), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_we", 64'(mem_write_enable), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single word, no gaps: write lands the cycle right after the last byte.
    pulse_start();
    chk("t2_busy", 64'(busy), 1);
    send_word(6'd0, 32'h1234_5678, 1'b0);
    chk("t2_we_now", 64'(mem_write_enable), 1);
    @(negedge clk);
    chk("t2_rx_ready", 64'(rx_ready), 1);
    chk("t2_word_count", 64'(word_count), 1);
    chk("t2_we_off", 64'(mem_write_enable), 0);
    chk("t2_data_hold", 64'(mem_data_in), 64'h1234_5678);

    // Asynchronous reset after two bytes of a partial word.
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 rst = 1'b0;
    #1;
    chk("t1_busy", 64'(busy), 0);
    chk("t1_rx_ready", 64'(rx_ready), 0);
    chk("t1_word_count", 64'(word_count), 0);
    chk("t1_mem_data", 64'(mem_data_in), 0);
    chk("t1_mem_addr", 64'(mem_address), 0);
    chk("t1_overflow", 64'(overflow), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_idle_busy", 64'(busy), 0);
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t1_idle_rx_ready", 64'(rx_ready), 0);
    end
    rx_valid = 1'b0;

    // Two words then the halt word, with random valid gaps.
    pulse_start();
    send_word(6'd0, 32'hA1B2_C3D4, 1'b1);
    send_word(6'd1, 32'h0000_0001, 1'b1);
    send_word(6'd2, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    chk("t3_done", 64'(done), 1);
    chk("t3_overflow", 64'(overflow), 0);
    chk("t3_word_count", 64'(word_count), 3);
    chk("t3_rx_ready", 64'(rx_ready), 0);
    chk("t3_busy", 64'(busy), 0);
    chk("t3_data_hold", 64'(mem_data_in), 64'hFFFF_FFFF);

    // Restart from DONE, and a start pulse mid-word that must be ignored.
    pulse_start();
    chk("t5_word_count_clr", 64'(word_count), 0);
    chk("t5_busy", 64'(busy), 1);
    chk("t5_done", 64'(done), 0);
    expect_write(6'd0, 32'h1122_3344);
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    pulse_start();
    send_byte(8'h22, 0);
    send_byte(8'h11, 0);
    send_word(6'd1, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    chk("t5_done_end", 64'(done), 1);
    chk("t5_word_count", 64'(word_count), 2);

    // Fill all 64 addresses without a halt word.
    pulse_start();
    for (int i = 0; i < 64; i++)
      send_word(6'(i), 32'h0100_0000 + 32'(i), 1'b0);
    @(negedge clk);
    chk("t4_done", 64'(done), 1);
    chk("t4_overflow", 64'(overflow), 1);
    chk("t4_word_count", 64'(word_count), 64);
    chk("t4_addr_hold", 64'(mem_address), 63);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_no_accept", 64'(rx_ready), 0);
    end
    rx_valid = 1'b0;
    chk("t4_word_count_hold", 64'(word_count), 64);

`ifdef MEM_LOADER_CHECKSUM_EN
    pulse_start();
    chk("t6_checksum_clr", 64'(checksum), 0);
    send_word(6'd0, 32'h0000_000F, 1'b0);
    send_word(6'd1, 32'h0000_00F0, 1'b0);
    send_word(6'd2, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    chk("t6_checksum", 64'(checksum), 64'hFFFF_FF00);
    @(negedge clk);
    chk("t6_checksum_hold", 64'(checksum), 64'hFFFF_FF00);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 0);
    chk("write_total", 64'(writes_seen), 64'(pushes));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
